sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master SRAM-like arbiter: data wins ties, grant locks until addr_ok; zero-latency request mux.
// An in-order id FIFO routes data_ok back; a full FIFO blocks new requests.
module sram_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        bus_sram_req,
  output logic        bus_sram_wr,
  output logic [1:0]  bus_sram_size,
  output logic [31:0] bus_sram_addr,
  output logic [3:0]  bus_sram_wstrb,
  output logic [31:0] bus_sram_wdata,
  input  logic        bus_sram_addr_ok,
  input  logic        bus_sram_data_ok,
  input  logic [31:0] bus_sram_rdata
);

  localparam int PW = $clog2(OT_DEPTH);
  localparam int CW = $clog2(OT_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OT_DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK_INST, LOCK_DATA} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sel_data;
  logic                sel_req;
  logic                handshake;
  logic                pop;
  logic                fifo_full;
  logic [OT_DEPTH-1:0] order;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;

  assign fifo_full = (count == DEPTH_C);
  assign handshake = bus_sram_req & bus_sram_addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A blocked or un-accepted request keeps the lock so the bus fields stay stable.
  always_comb begin
    state_nxt = IDLE;
    if (handshake) begin
      state_nxt = IDLE;
    end else if (sel_req) begin
      state_nxt = sel_data ? LOCK_DATA : LOCK_INST;
    end
  end

  always_comb begin
    sel_data = 1'b0;
    case (state)
      LOCK_INST: sel_data = 1'b0;
      LOCK_DATA: sel_data = 1'b1;
      default:   sel_data = data_sram_req;
    endcase
    sel_req        = sel_data ? data_sram_req : inst_sram_req;
    bus_sram_req   = resetn & sel_req & ~fifo_full;
    bus_sram_wr    = sel_data ? data_sram_wr    : inst_sram_wr;
    bus_sram_size  = sel_data ? data_sram_size  : inst_sram_size;
    bus_sram_addr  = sel_data ? data_sram_addr  : inst_sram_addr;
    bus_sram_wstrb = sel_data ? data_sram_wstrb : inst_sram_wstrb;
    bus_sram_wdata = sel_data ? data_sram_wdata : inst_sram_wdata;

    inst_sram_addr_ok = handshake & ~sel_data;
    data_sram_addr_ok = handshake &  sel_data;

    pop               = resetn & bus_sram_data_ok & (count != '0);
    inst_sram_data_ok = pop & ~order[rd_ptr];
    data_sram_data_ok = pop &  order[rd_ptr];
  end

  assign inst_sram_rdata = bus_sram_rdata;
  assign data_sram_rdata = bus_sram_rdata;

  always_comb begin
    count_nxt = count;
    case ({handshake, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers are exactly log2(OT_DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      order  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (handshake) begin
        order[wr_ptr] <= sel_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: per-cycle vector table plus an in-order id scoreboard for data_ok routing.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0]  inst_sram_wstrb;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic        bus_sram_req, bus_sram_wr, bus_sram_addr_ok, bus_sram_data_ok;
  logic [1:0]  bus_sram_size;
  logic [31:0] bus_sram_addr, bus_sram_wdata, bus_sram_rdata;
  logic [3:0]  bus_sram_wstrb;

  sram_arbiter #(.OT_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .bus_sram_req(bus_sram_req), .bus_sram_wr(bus_sram_wr), .bus_sram_size(bus_sram_size),
    .bus_sram_addr(bus_sram_addr), .bus_sram_wstrb(bus_sram_wstrb), .bus_sram_wdata(bus_sram_wdata),
    .bus_sram_addr_ok(bus_sram_addr_ok), .bus_sram_data_ok(bus_sram_data_ok), .bus_sram_rdata(bus_sram_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] SI = 2'd0, SD = 2'd1, SX = 2'd2;
  localparam logic [31:0] I_ADDR = 32'h1000_0040, D_ADDR = 32'h2000_0080;
  localparam logic [38:0] I_FLD = {1'b0, 2'd2, 4'hf, 32'h1111_1111};
  localparam logic [38:0] D_FLD = {1'b1, 2'd1, 4'h3, 32'h2222_2222};

  typedef struct {
    logic       ir, dr, aok, dok;
    logic       e_req;
    logic [1:0] e_sel;
    logic       e_iaok, e_daok;
  } vec_t;

  vec_t vecs[$];
  logic sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic ir, dr, aok, dok, e_req, input logic [1:0] e_sel,
                              input logic e_iaok, e_daok);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok;
    v.e_req = e_req; v.e_sel = e_sel; v.e_iaok = e_iaok; v.e_daok = e_daok;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " bus_req"},   64'(bus_sram_req),      64'(0));
    check({tag, " inst_aok"},  64'(inst_sram_addr_ok), 64'(0));
    check({tag, " data_aok"},  64'(data_sram_addr_ok), 64'(0));
    check({tag, " inst_dok"},  64'(inst_sram_data_ok), 64'(0));
    check({tag, " data_dok"},  64'(data_sram_data_ok), 64'(0));
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic        e_idok, e_ddok;
    logic [31:0] rd;
    string       t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    inst_sram_req    = v.ir;
    data_sram_req    = v.dr;
    bus_sram_addr_ok = v.aok;
    bus_sram_data_ok = v.dok;
    rd               = $urandom;
    bus_sram_rdata   = rd;
    #1;
    check({t, " bus_req"},  64'(bus_sram_req),      64'(v.e_req));
    check({t, " inst_aok"}, 64'(inst_sram_addr_ok), 64'(v.e_iaok));
    check({t, " data_aok"}, 64'(data_sram_addr_ok), 64'(v.e_daok));
    if (v.e_sel == SI) begin
      check({t, " addr"},   64'(bus_sram_addr), 64'(I_ADDR));
      check({t, " fields"}, 64'({bus_sram_wr, bus_sram_size, bus_sram_wstrb, bus_sram_wdata}), 64'(I_FLD));
    end else if (v.e_sel == SD) begin
      check({t, " addr"},   64'(bus_sram_addr), 64'(D_ADDR));
      check({t, " fields"}, 64'({bus_sram_wr, bus_sram_size, bus_sram_wstrb, bus_sram_wdata}), 64'(D_FLD));
    end
    e_idok = 1'b0;
    e_ddok = 1'b0;
    if (v.dok && sb.size() > 0) begin
      if (sb[0]) e_ddok = 1'b1;
      else       e_idok = 1'b1;
      void'(sb.pop_front());
    end
    check({t, " inst_dok"},   64'(inst_sram_data_ok), 64'(e_idok));
    check({t, " data_dok"},   64'(data_sram_data_ok), 64'(e_ddok));
    check({t, " inst_rdata"}, 64'(inst_sram_rdata),   64'(rd));
    check({t, " data_rdata"}, 64'(data_sram_rdata),   64'(rd));
    if (v.e_req && v.aok) sb.push_back(v.e_sel == SD);
  endtask

  initial begin
    inst_sram_wr = I_FLD[38]; inst_sram_size = I_FLD[37:36]; inst_sram_wstrb = I_FLD[35:32];
    inst_sram_wdata = I_FLD[31:0]; inst_sram_addr = I_ADDR;
    data_sram_wr = D_FLD[38]; data_sram_size = D_FLD[37:36]; data_sram_wstrb = D_FLD[35:32];
    data_sram_wdata = D_FLD[31:0]; data_sram_addr = D_ADDR;
    bus_sram_rdata = 32'h0;

    // Reset held with every request input active: outputs must stay quiet.
    resetn = 1'b0;
    inst_sram_req = 1'b1; data_sram_req = 1'b1; bus_sram_addr_ok = 1'b1; bus_sram_data_ok = 1'b1;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_sram_addr_ok = 1'b0; bus_sram_data_ok = 1'b0;
    resetn = 1'b1;

    //                ir dr ak dk  req sel iak dak
    vecs.push_back(mk(1, 1, 1, 0,  1, SD, 0, 1));  // tie goes to data
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  1, SI, 0, 0));  // inst waits for addr_ok
    vecs.push_back(mk(1, 1, 0, 0,  1, SI, 0, 0));  // data arrives, lock holds
    vecs.push_back(mk(1, 1, 0, 0,  1, SI, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0,  1, SI, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, SD, 0, 1));  // data granted right after
    vecs.push_back(mk(1, 0, 1, 0,  1, SI, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));  // in-order return I, D, I
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));  // spurious data_ok at empty
    vecs.push_back(mk(1, 0, 1, 0,  1, SI, 1, 0));  // fill to four
    vecs.push_back(mk(0, 1, 1, 0,  1, SD, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0,  1, SI, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0,  1, SD, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0,  0, SD, 0, 0));  // full: blocked
    vecs.push_back(mk(1, 0, 1, 1,  0, SD, 0, 0));  // pop while full: still blocked this cycle
    vecs.push_back(mk(1, 0, 1, 0,  1, SI, 1, 0));  // slot freed next cycle
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));  // down to three
    vecs.push_back(mk(0, 1, 1, 1,  1, SD, 0, 1));  // push+pop at three
    vecs.push_back(mk(1, 0, 1, 0,  1, SI, 1, 0));  // reaches four only if count stayed three
    vecs.push_back(mk(1, 0, 1, 0,  0, SI, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, SX, 0, 0));  // two left outstanding

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset with two entries outstanding.
    @(negedge clk);
    inst_sram_req = 1'b1; data_sram_req = 1'b1; bus_sram_addr_ok = 1'b1; bus_sram_data_ok = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    sb.delete();
    @(negedge clk);
    inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_sram_addr_ok = 1'b0; bus_sram_data_ok = 1'b0;
    resetn = 1'b1;
    apply(mk(0, 0, 0, 1, 0, SX, 0, 0), 100);  // stale entries must not route
    apply(mk(1, 0, 1, 0, 1, SI, 1, 0), 101);
    apply(mk(0, 0, 0, 1, 0, SX, 0, 0), 102);  // fresh entry routes to inst
    apply(mk(0, 0, 0, 1, 0, SX, 0, 0), 103);  // and the fifo is empty again

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
